// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator with a two-entry (main + skid) output buffer.
// in_ready comes straight from the skid-valid flop so it never depends on out_ready combinationally.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             illegal
);

    typedef enum logic [2:0] {
        SEL_I     = 3'd0,
        SEL_U     = 3'd1,
        SEL_S     = 3'd2,
        SEL_B     = 3'd3,
        SEL_J     = 3'd4,
        SEL_SHAMT = 3'd5,
        SEL_ZIMM  = 3'd6,
        SEL_RSVD  = 3'd7
    } imm_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } beat_t;

    beat_t new_beat;
    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    logic  accept;
    logic  xfer;

    // The opcode field carries no immediate bits.
    logic  unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        new_beat.imm     = XLEN'($signed(instr[31:20]));
        new_beat.tag     = tag_in;
        new_beat.illegal = 1'b0;
        case (imm_sel_e'(imm_sel))
            SEL_I:     ;
            SEL_U:     new_beat.imm = XLEN'($signed({instr[31:12], 12'b0}));
            SEL_S:     new_beat.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            SEL_B:     new_beat.imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                                     instr[11:8], 1'b0}));
            SEL_J:     new_beat.imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                                     instr[30:21], 1'b0}));
            SEL_SHAMT: new_beat.imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            SEL_ZIMM:  new_beat.imm = XLEN'(instr[19:15]);
            SEL_RSVD:  new_beat.illegal = 1'b1;
            default:   ;
        endcase
    end

    assign accept = in_valid && !skid_valid_q;
    assign xfer   = main_valid_q && out_ready;

    // A full skid always drains into main first; in_ready is low that cycle so no new beat races it.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            if (xfer) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || xfer) begin
                main_d       = new_beat;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_beat;
                skid_valid_d = 1'b1;
            end
        end else if (xfer) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign imm_out   = main_q.imm;
    assign tag_out   = main_q.tag;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream,
// a scoreboard queue tracks accepted beats and scenario tasks add directed checks.
module tb_imm_gen_pipe;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      instr = '0;
    logic [2:0]       imm_sel = '0;
    logic [TAG_W-1:0] tag_in = '0;

    logic             in_ready32, out_valid32, ill32;
    logic [31:0]      imm32;
    logic [TAG_W-1:0] tag32;
    logic             in_ready64, out_valid64, ill64;
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag64;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]      instr;
        logic [2:0]       sel;
        logic [TAG_W-1:0] tag;
    } beat_t;

    beat_t sb[$];

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .imm_sel(imm_sel), .tag_in(tag_in),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm_out(imm32), .tag_out(tag32), .illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_sel(imm_sel), .tag_in(tag_in),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm_out(imm64), .tag_out(tag64), .illegal(ill64)
    );

    always #5 clk = ~clk;

    // Reference decode written out at 64 bits; the XLEN=32 expectation is its low half.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s, input int xl);
        case (s)
            3'd1:    return {{32{i[31]}}, i[31:12], 12'h000};
            3'd2:    return {{52{i[31]}}, i[31:25], i[11:7]};
            3'd3:    return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4:    return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd5:    return (xl == 64) ? {58'h0, i[25:20]} : {59'h0, i[24:20]};
            3'd6:    return {59'h0, i[19:15]};
            default: return {{52{i[31]}}, i[31:20]};
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s,
                         input logic [TAG_W-1:0] t);
        in_valid = v;
        instr    = i;
        imm_sel  = s;
        tag_in   = t;
    endtask

    // Mid-cycle: an output beat seen with out_ready will transfer, an input beat seen with in_ready will be accepted.
    task automatic scoreboard_monitor();
        beat_t       b;
        logic [63:0] e64;
        logic [31:0] e32;
        logic        e_ill;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid32 && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL sb_unexpected_beat got tag=%h, required no beat", tag32);
                    end else begin
                        b     = sb.pop_front();
                        e64   = ref_imm(b.instr, b.sel, 64);
                        e32   = ref_imm(b.instr, b.sel, 32) & 64'hFFFF_FFFF;
                        e_ill = (b.sel == 3'd7);
                        if ({imm32, tag32, ill32} !== {e32, b.tag, e_ill}) begin
                            failures++;
                            $display("[TB] FAIL sb_beat32 got imm=%h tag=%h ill=%b, required imm=%h tag=%h ill=%b",
                                     imm32, tag32, ill32, e32, b.tag, e_ill);
                        end
                        checks++;
                        if ({out_valid64, imm64, tag64, ill64} !== {1'b1, e64, b.tag, e_ill}) begin
                            failures++;
                            $display("[TB] FAIL sb_beat64 got v=%b imm=%h tag=%h ill=%b, required v=1 imm=%h tag=%h ill=%b",
                                     out_valid64, imm64, tag64, ill64, e64, b.tag, e_ill);
                        end
                    end
                end
                if (in_valid && in_ready32)
                    sb.push_back('{instr: instr, sel: imm_sel, tag: tag_in});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 8'h00);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid32, imm32, tag32, ill32, in_ready32} !== {1'b0, 32'h0, 8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_state32 got v=%b imm=%h tag=%h ill=%b rdy=%b, required 0/0/0/0/1",
                     out_valid32, imm32, tag32, ill32, in_ready32);
        end
        checks++;
        if ({out_valid64, imm64, tag64, ill64, in_ready64} !== {1'b0, 64'h0, 8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_state64 got v=%b imm=%h tag=%h ill=%b rdy=%b, required 0/0/0/0/1",
                     out_valid64, imm64, tag64, ill64, in_ready64);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid32, in_ready32} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL reset_release got v=%b rdy=%b, required v=0 rdy=1", out_valid32, in_ready32);
        end
    endtask

    // Known-answer vectors issued back to back; each must appear exactly one cycle after it is offered.
    task automatic test_plan_vectors();
        logic [31:0] v_instr[9] = '{32'hFFF00093, 32'h123450B7, 32'h800000B7, 32'hFE112E23,
                                    32'hFE000EE3, 32'h0080006F, 32'h80000013, 32'h03F01013,
                                    32'h000F8073};
        logic [2:0]  v_sel[9]   = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd5, 3'd6};
        logic [31:0] v_exp32[9] = '{32'hFFFFFFFF, 32'h12345000, 32'h80000000, 32'hFFFFFFFC,
                                    32'hFFFFFFFC, 32'h00000008, 32'hFFFFF800, 32'h0000001F,
                                    32'h0000001F};
        logic [63:0] v_exp64[9] = '{64'hFFFFFFFF_FFFFFFFF, 64'h00000000_12345000,
                                    64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFFFFFC,
                                    64'hFFFFFFFF_FFFFFFFC, 64'h00000000_00000008,
                                    64'hFFFFFFFF_FFFFF800, 64'h00000000_0000003F,
                                    64'h00000000_0000001F};
        logic        v_ill[9]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0]  t;
        out_ready = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (k < 9) drive(1'b1, v_instr[k], v_sel[k], 8'h11 + 8'(k));
            else       drive(1'b0, 32'h0, 3'd0, 8'h00);
            @(negedge clk);
            if (k > 0) begin
                t = 8'h11 + 8'(k - 1);
                checks++;
                if ({out_valid32, imm32, tag32, ill32} !== {1'b1, v_exp32[k-1], t, v_ill[k-1]}) begin
                    failures++;
                    $display("[TB] FAIL vec32_%0d got v=%b imm=%h tag=%h ill=%b, required v=1 imm=%h tag=%h ill=%b",
                             k - 1, out_valid32, imm32, tag32, ill32, v_exp32[k-1], t, v_ill[k-1]);
                end
                checks++;
                if (imm64 !== v_exp64[k-1]) begin
                    failures++;
                    $display("[TB] FAIL vec64_%0d got imm=%h, required %h", k - 1, imm64, v_exp64[k-1]);
                end
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({out_valid32, imm32, tag32, ill32} !== {1'b0, 32'h0000001F, 8'h19, 1'b0}) begin
            failures++;
            $display("[TB] FAIL idle_hold got v=%b imm=%h tag=%h ill=%b, required v=0 imm=0000001f tag=19 ill=0",
                     out_valid32, imm32, tag32, ill32);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        logic       c_taken;
        out_ready = 1'b0;
        @(posedge clk); #1; drive(1'b1, 32'h00500093, 3'd0, 8'd1);
        @(posedge clk); #1; drive(1'b1, 32'hFFF00093, 3'd0, 8'd2);
        @(negedge clk);
        checks++;
        if ({out_valid32, tag32, in_ready32} !== {1'b1, 8'd1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL bp_first got v=%b tag=%h rdy=%b, required v=1 tag=01 rdy=1",
                     out_valid32, tag32, in_ready32);
        end
        @(posedge clk); #1; drive(1'b1, 32'h123450B7, 3'd1, 8'd3);
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_in_ready_low got rdy32=%b rdy64=%b, required 0", in_ready32, in_ready64);
        end
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if ({out_valid32, imm32, tag32, ill32, in_ready32} !== {1'b1, 32'd5, 8'd1, 1'b0, 1'b0}) begin
                failures++;
                $display("[TB] FAIL bp_stall_%0d got v=%b imm=%h tag=%h ill=%b rdy=%b, required 1/00000005/01/0/0",
                         s, out_valid32, imm32, tag32, ill32, in_ready32);
            end
        end
        @(posedge clk); #1; out_ready = 1'b1;
        c_taken = 1'b0;
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            @(negedge clk);
            if (out_valid32 && out_ready) got.push_back(tag32);
            if (in_valid && in_ready32) c_taken = 1'b1;
            @(posedge clk); #1;
            if (c_taken) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() != 3 || !c_taken) begin
            failures++;
            $display("[TB] FAIL bp_drain_count got beats=%0d c_taken=%b, required beats=3 c_taken=1",
                     got.size(), c_taken);
        end else begin
            checks++;
            if ({got[0], got[1], got[2]} !== {8'd1, 8'd2, 8'd3}) begin
                failures++;
                $display("[TB] FAIL bp_order got %h %h %h, required 01 02 03", got[0], got[1], got[2]);
            end
        end
    endtask

    // Random traffic with random back-pressure; stalled outputs must not move.
    task automatic test_random();
        logic        prev_stall = 1'b0;
        logic [41:0] snap = '0;
        logic [7:0]  t = 8'h40;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) drive(1'b1, $urandom, 3'($urandom_range(0, 7)), t);
            else                           in_valid = 1'b0;
            t++;
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if ({out_valid32, imm32, tag32, ill32} !== snap) begin
                    failures++;
                    $display("[TB] FAIL stall_stable got %h, required %h",
                             {out_valid32, imm32, tag32, ill32}, snap);
                end
            end
            prev_stall = out_valid32 && !out_ready;
            snap       = {out_valid32, imm32, tag32, ill32};
        end
        @(posedge clk); #1; in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        @(posedge clk); #1; drive(1'b1, 32'h00200093, 3'd0, 8'h21);
        @(posedge clk); #1; drive(1'b1, 32'h00300093, 3'd0, 8'h22);
        @(posedge clk); #1; drive(1'b1, 32'h00400093, 3'd0, 8'h23);
        @(negedge clk);
        checks++;
        if ({out_valid32, in_ready32} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL rst_mid_full got v=%b rdy=%b, required v=1 rdy=0", out_valid32, in_ready32);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({out_valid32, in_ready32, out_valid64, in_ready64} !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL rst_mid_async got v32=%b rdy32=%b v64=%b rdy64=%b, required 0/1/0/1",
                     out_valid32, in_ready32, out_valid64, in_ready64);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_quiet got v=%b, required 0", out_valid32);
        end
        out_ready = 1'b1;
        @(posedge clk); #1; drive(1'b1, 32'h00100093, 3'd0, 8'h33);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid32, imm32, tag32} !== {1'b1, 32'd1, 8'h33}) begin
            failures++;
            $display("[TB] FAIL rst_mid_first got v=%b imm=%h tag=%h, required v=1 imm=00000001 tag=33",
                     out_valid32, imm32, tag32);
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int c = 0; c < 10 && (sb.size() != 0 || out_valid32); c++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || out_valid32 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_empty got pending=%0d v=%b, required pending=0 v=0", sb.size(), out_valid32);
        end
    endtask

    initial begin
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_plan_vectors();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
